div_seq_16: RTL and testbench

- Sequential unsigned restoring divider, shift-subtract; the inverse datapath of the shift-add multiplier accumulator in the MIPS CPU arithmetic unit.
- Accepts a WIDTH-bit dividend and divisor on a start pulse.
- Performs one restoring iteration per clock.
- Returns quotient and remainder with a one-cycle done pulse.
- Feeds the divu path and HI/LO writeback.

---
 rtl/div_seq_16.sv | 110 +++++++++++
 tb/tb_div_seq_16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq_16.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock,
// quotient/remainder registered at completion with a one-cycle done pulse.
module div_seq_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dreg_q;
   logic [CNT_W-1:0] count_q;
   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;

   logic [WIDTH:0]   remShift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic             accept;

   // A restore only happens when the shifted partial remainder is below the
   // divisor, so the kept remainder always fits in WIDTH bits.
   always_comb begin
      remShift = {rem_q, quo_q[WIDTH-1]};
      trial    = remShift - {1'b0, dreg_q};
      rem_d    = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
   end

   assign accept = start && (state_q != CALC);

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dreg_q      <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            CALC: begin
               rem_q   <= rem_d;
               quo_q   <= quo_d;
               count_q <= count_q + 1'b1;
               if (count_q == LAST_CNT) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= quo_d;
                  remainder_q <= rem_d;
               end
            end
            default: begin
               done_q <= 1'b0;
               if (accept) begin
                  dreg_q  <= divisor;
                  rem_q   <= '0;
                  quo_q   <= dividend;
                  count_q <= '0;
                  dbz_q   <= 1'b0;
                  if (divisor == '0) begin
                     // Zero divisor short-circuits straight to a flagged result.
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     dbz_q       <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;

endmodule

// File: tb/tb_div_seq_16.sv
// Self-checking bench for div_seq_16: directed corner cases plus random
// operands compared against plain-arithmetic division.
module tb_div_seq_16;

   logic        clock;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [15:0] quotient;
   logic [15:0] remainder;

   int compareCount;
   int mismatchCount;
   int cyc;
   int busyCnt;

   div_seq_16 #(.WIDTH(16)) dut (
      .clock       (clock),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .quotient    (quotient),
      .remainder   (remainder)
   );

   // Free-running 10 ns clock; all sampling happens on the falling edge.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic void refDiv(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r, output logic z);
      if (b == 16'd0) begin
         q = 16'hFFFF;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   // Drives a one-cycle start; returns at the falling edge after the accepting edge.
   task automatic startOp(input logic [15:0] a, input logic [15:0] b);
      @(negedge clock);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clock);
      start    = 1'b0;
      cyc      = 0;
      busyCnt  = 0;
   endtask

   task automatic stepCycle();
      if (busy) busyCnt++;
      @(negedge clock);
      cyc++;
   endtask

   task automatic runUntilDone();
      while (!done && cyc < 40) stepCycle();
   endtask

   task automatic checkResult(input string tag, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] q, r;
      logic        z;
      refDiv(a, b, q, r, z);
      checkOutput({tag, ".latency"}, 32'(cyc), (b == 16'd0) ? 32'd0 : 32'd16);
      checkOutput({tag, ".busyCycles"}, 32'(busyCnt), (b == 16'd0) ? 32'd0 : 32'd16);
      checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, ".quotient"}, {16'd0, quotient}, {16'd0, q});
      checkOutput({tag, ".remainder"}, {16'd0, remainder}, {16'd0, r});
      checkOutput({tag, ".divByZero"}, {31'd0, div_by_zero}, {31'd0, z});
   endtask

   // Full operation: start, wait for done, check, then confirm done lasts one cycle.
   task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b);
      startOp(a, b);
      runUntilDone();
      checkResult(tag, a, b);
      @(negedge clock);
      checkOutput({tag, ".donePulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      int          doneSeen;
      compareCount  = 0;
      mismatchCount = 0;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset.busy", {31'd0, busy}, 32'd0);
      checkOutput("reset.done", {31'd0, done}, 32'd0);
      checkOutput("reset.quotient", {16'd0, quotient}, 32'd0);
      checkOutput("reset.remainder", {16'd0, remainder}, 32'd0);
      rst = 1'b0;

      applyStimulus("d100_7", 16'd100, 16'd7);
      applyStimulus("dFFFF_1", 16'hFFFF, 16'd1);
      applyStimulus("d5_9", 16'd5, 16'd9);
      applyStimulus("d0_3", 16'd0, 16'd3);
      applyStimulus("dFFFF_FFFF", 16'hFFFF, 16'hFFFF);
      applyStimulus("d1234_0", 16'd1234, 16'd0);
      applyStimulus("d9_3", 16'd9, 16'd3);

      // Start during CALC must be ignored.
      startOp(16'd200, 16'd9);
      repeat (4) stepCycle();
      start    = 1'b1;
      dividend = 16'd50;
      divisor  = 16'd5;
      stepCycle();
      start    = 1'b0;
      runUntilDone();
      checkResult("busyStart", 16'd200, 16'd9);
      doneSeen = 0;
      repeat (20) begin
         @(negedge clock);
         if (done) doneSeen++;
      end
      checkOutput("busyStart.extraDone", 32'(doneSeen), 32'd0);

      // Back-to-back: second start held during the DONE cycle.
      startOp(16'd100, 16'd7);
      runUntilDone();
      checkResult("b2bFirst", 16'd100, 16'd7);
      start    = 1'b1;
      dividend = 16'd81;
      divisor  = 16'd4;
      @(negedge clock);
      start    = 1'b0;
      cyc      = 0;
      busyCnt  = 0;
      checkOutput("b2b.busyAfterAccept", {31'd0, busy}, 32'd1);
      checkOutput("b2b.quotientHeld", {16'd0, quotient}, 32'd14);
      runUntilDone();
      checkResult("b2bSecond", 16'd81, 16'd4);

      // Reset mid-operation discards everything.
      startOp(16'd1000, 16'd3);
      repeat (7) stepCycle();
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
      checkOutput("midReset.quotient", {16'd0, quotient}, 32'd0);
      checkOutput("midReset.remainder", {16'd0, remainder}, 32'd0);
      doneSeen = 0;
      repeat (20) begin
         if (done) doneSeen++;
         @(negedge clock);
      end
      checkOutput("midReset.noDone", 32'(doneSeen), 32'd0);
      applyStimulus("d1000_3", 16'd1000, 16'd3);

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rb = 16'd0;
            1: rb = 16'($urandom_range(1, 15));
            2: rb = 16'($urandom_range(1, 255));
            default: rb = 16'($urandom);
         endcase
         applyStimulus($sformatf("rand%0d", i), ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
